// File: rtl/mem_access_unit_if.sv
// Request/response and RAM-side bus of the load/store unit.
interface mem_access_unit_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     Req_Valid;
  logic                     Req_Ready;
  logic                     Req_Write;
  logic [1:0]               Req_Size;
  logic                     Req_Unsigned;
  logic [ADDRESS_WIDTH-1:0] Req_Addr;
  logic [DATA_WIDTH-1:0]    Req_WData;
  logic                     Resp_Valid;
  logic [DATA_WIDTH-1:0]    Resp_Data;
  logic                     Resp_Err;
  logic [ADDRESS_WIDTH-1:0] Mem_Addr;
  logic [DATA_WIDTH-1:0]    Mem_Data;
  logic                     Mem_W_EN;
  logic [1:0]               Mem_Sel;
  logic [DATA_WIDTH-1:0]    Mem_RData;

  modport slave (
    input  Req_Valid, Req_Write, Req_Size,
    input  Req_Unsigned, Req_Addr, Req_WData,
    input  Mem_RData,
    output Req_Ready, Resp_Valid, Resp_Data,
    output Resp_Err, Mem_Addr, Mem_Data,
    output Mem_W_EN, Mem_Sel
  );

  modport master (
    output Req_Valid, Req_Write, Req_Size,
    output Req_Unsigned, Req_Addr, Req_WData,
    output Mem_RData,
    input  Req_Ready, Resp_Valid, Resp_Data,
    input  Resp_Err, Mem_Addr, Mem_Data,
    input  Mem_W_EN, Mem_Sel
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator with wait states and sub-word extension.
// MEM_ACCESS_MISALIGN_TRAP_EN: misaligned requests return an error.
module mem_access_unit #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int WAIT_STATES   = 1
) (
  input  logic CLK,
  input  logic RST,
  mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [3:0]               cnt;
  logic                     r_write;
  logic                     r_unsigned;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_data;
  logic [1:0]               mem_sel;
  logic [DATA_WIDTH-1:0]    resp_data;
  logic                     resp_err;

  logic                     is_half;
  logic                     is_word;
  logic                     trap;
  logic                     last;
  logic                     accept;
  logic [ADDRESS_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0]    ext;
  logic                     fill_b;
  logic                     fill_h;

  assign is_half = bus.Req_Size == 2'b01;
  assign is_word = bus.Req_Size[0] == bus.Req_Size[1];
  assign last    = cnt == 4'd0;
  assign accept  = state == IDLE && bus.Req_Valid;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign trap = (is_half && bus.Req_Addr[0]) ||
                (is_word && bus.Req_Addr[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  // Low address bits are dropped so the RAM only sees aligned accesses.
  always_comb begin
    acc_addr = bus.Req_Addr;
    if (is_half) acc_addr[0] = 1'b0;
    if (is_word) acc_addr[1:0] = 2'b00;
  end

  assign fill_b = !r_unsigned && bus.Mem_RData[7];
  assign fill_h = !r_unsigned && bus.Mem_RData[15];

  always_comb begin
    ext = bus.Mem_RData;
    unique case (1'b1)
      mem_sel == 2'b10:
        ext = {{(DATA_WIDTH-8){fill_b}}, bus.Mem_RData[7:0]};
      mem_sel == 2'b01:
        ext = {{(DATA_WIDTH-16){fill_h}}, bus.Mem_RData[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.Req_Valid) state_nxt = trap ? RESP : ACCESS;
      ACCESS:  if (last) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt        <= '0;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_sel    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        r_write    <= bus.Req_Write;
        r_unsigned <= bus.Req_Unsigned;
        cnt        <= 4'(WAIT_STATES);
        if (trap) begin
          resp_data <= '0;
          resp_err  <= 1'b1;
        end else begin
          mem_addr <= acc_addr;
          mem_data <= bus.Req_WData;
          mem_sel  <= bus.Req_Size;
        end
      end
      if (state == ACCESS) begin
        if (!last) cnt <= cnt - 4'd1;
        if (last) begin
          resp_data <= r_write ? '0 : ext;
          resp_err  <= 1'b0;
        end
      end
    end
  end

  assign bus.Req_Ready  = state == IDLE && !RST;
  assign bus.Resp_Valid = state == RESP;
  assign bus.Resp_Data  = resp_data;
  assign bus.Resp_Err   = resp_err;
  assign bus.Mem_Addr   = mem_addr;
  assign bus.Mem_Data   = mem_data;
  assign bus.Mem_Sel    = mem_sel;
  assign bus.Mem_W_EN   = state == ACCESS && last &&
                          r_write && !RST;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus random bench for mem_access_unit against a
// request-level memory model.
module tb_mem_access_unit;
  localparam int WS = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_access_unit #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH(32),
    .WAIT_STATES(WS)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int resp_cnt = 0;
  int wen_cnt = 0;

  logic [31:0] ram     [64];
  logic [31:0] ref_mem [64];
  logic [31:0] rd_word;
  logic [4:0]  rd_sh;

  function automatic logic [31:0] merge(
    input logic [31:0] old, input logic [31:0] d,
    input logic [1:0] sel, input logic [31:0] a);
    logic [31:0] m;
    logic [4:0]  sh;
    case (sel)
      2'b01: begin
        sh = {a[1], 4'b0};
        m  = 32'h0000FFFF << sh;
        return (old & ~m) | ((d & 32'h0000FFFF) << sh);
      end
      2'b10: begin
        sh = {a[1:0], 3'b0};
        m  = 32'h000000FF << sh;
        return (old & ~m) | ((d & 32'h000000FF) << sh);
      end
      default: return d;
    endcase
  endfunction

  // RAM: combinational read, right-justified
  always_comb begin
    rd_word = ram[bus.Mem_Addr[7:2]];
    rd_sh   = 5'd0;
    bus.Mem_RData = rd_word;
    case (bus.Mem_Sel)
      2'b01: begin
        rd_sh = {bus.Mem_Addr[1], 4'b0};
        bus.Mem_RData = (rd_word >> rd_sh) & 32'h0000FFFF;
      end
      2'b10: begin
        rd_sh = {bus.Mem_Addr[1:0], 3'b0};
        bus.Mem_RData = (rd_word >> rd_sh) & 32'h000000FF;
      end
      default: ;
    endcase
  end

  always @(posedge clk)
    if (bus.Mem_W_EN)
      ram[bus.Mem_Addr[7:2]] <= merge(ram[bus.Mem_Addr[7:2]],
        bus.Mem_Data, bus.Mem_Sel, bus.Mem_Addr);

  always @(negedge clk) begin
    if (bus.Resp_Valid) resp_cnt++;
    if (bus.Mem_W_EN)   wen_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] a,
                                        input logic [1:0] sz);
    if (sz == 2'b01) return a & ~32'd1;
    if (sz == 2'b10) return a;
    return a & ~32'd3;
  endfunction

  function automatic bit misal(input logic [31:0] a,
                               input logic [1:0] sz);
    return align(a, sz) != a;
  endfunction

  // Expected load value from the reference memory.
  function automatic logic [31:0] ref_load(input logic [31:0] a,
                                           input logic [1:0] sz,
                                           input bit uns);
    logic [31:0] w, v;
    w = ref_mem[a[7:2]];
    if (sz == 2'b10) begin
      v = (w >> (8 * a[1:0])) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 2'b01) begin
      v = (w >> (16 * a[1])) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic transact(input bit w, input logic [1:0] sz,
                          input bit uns, input logic [31:0] a,
                          input logic [31:0] d,
                          output logic [31:0] got_d,
                          output logic got_e);
    int lat, wens, wen_lat;
    bit got, trap;
    logic [31:0] wen_addr, exp_d, al;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    trap = misal(a, sz);
`else
    trap = 1'b0;
`endif
    al = align(a, sz);
    exp_d = (w || trap) ? 32'd0 : ref_load(al, sz, uns);
    lat = 0; wens = 0; wen_lat = 0; got = 0;
    wen_addr = '0; got_d = '0; got_e = 1'b0;
    check("req_ready", 32'(bus.Req_Ready), 32'd1);
    bus.Req_Valid = 1'b1;
    bus.Req_Write = w;
    bus.Req_Size = sz;
    bus.Req_Unsigned = uns;
    bus.Req_Addr = a;
    bus.Req_WData = d;
    @(negedge clk);
    bus.Req_Valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (bus.Mem_W_EN) begin
        wens++;
        wen_lat = i;
        wen_addr = bus.Mem_Addr;
      end
      if (bus.Resp_Valid) begin
        got = 1;
        lat = i;
        got_d = bus.Resp_Data;
        got_e = bus.Resp_Err;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (!got) check("resp_timeout", 32'd0, 32'd1);
    check("resp_latency", 32'(lat), trap ? 32'd1 : 32'(WS + 2));
    check("resp_data", got_d, exp_d);
    check("resp_err", 32'(got_e), 32'(trap));
    check("wen_pulses", 32'(wens), (w && !trap) ? 32'd1 : 32'd0);
    if (w && !trap) begin
      check("wen_cycle", 32'(wen_lat), 32'(WS + 1));
      check("wen_addr", wen_addr, al);
      ref_mem[al[7:2]] = merge(ref_mem[al[7:2]], d, sz, al);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic e;
    int r0, w0, acc, last;

    for (int i = 0; i < 64; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[4] = 32'h8001F000;
    ref_mem[4] = 32'h8001F000;

    bus.Req_Valid = 1'b1;
    bus.Req_Write = 1'b1;
    bus.Req_Size = 2'b00;
    bus.Req_Unsigned = 1'b0;
    bus.Req_Addr = 32'h40;
    bus.Req_WData = 32'h12345678;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_ready", 32'(bus.Req_Ready), 32'd0);
      check("rst_wen", 32'(bus.Mem_W_EN), 32'd0);
      check("rst_resp_valid", 32'(bus.Resp_Valid), 32'd0);
    end
    check("rst_mem_addr", bus.Mem_Addr, 32'd0);
    check("rst_resp_data", bus.Resp_Data, 32'd0);
    check("rst_resp_err", 32'(bus.Resp_Err), 32'd0);
    check("rst_mem_sel", 32'(bus.Mem_Sel), 32'd0);
    rst = 1'b0;
    bus.Req_Valid = 1'b0;
    #1;
    check("rel_ready", 32'(bus.Req_Ready), 32'd1);

    transact(1, 2'b00, 0, 32'h20, 32'hDEADBEEF, d, e);
    transact(0, 2'b00, 0, 32'h20, 32'h0, d, e);
    check("ld_word_const", d, 32'hDEADBEEF);
    transact(0, 2'b10, 0, 32'h11, 32'h0, d, e);
    check("ld_byte_s", d, 32'hFFFFFFF0);
    transact(0, 2'b10, 1, 32'h11, 32'h0, d, e);
    check("ld_byte_u", d, 32'h000000F0);
    transact(0, 2'b01, 0, 32'h12, 32'h0, d, e);
    check("ld_half_s", d, 32'hFFFF8001);
    transact(1, 2'b00, 0, 32'h22, 32'hCAFEF00D, d, e);
    transact(0, 2'b00, 0, 32'h20, 32'h0, d, e);

    r0 = resp_cnt;
    w0 = wen_cnt;
    bus.Req_Valid = 1'b1;
    bus.Req_Write = 1'b1;
    bus.Req_Size = 2'b00;
    bus.Req_Addr = 32'h30;
    bus.Req_WData = 32'hA5A5A5A5;
    @(negedge clk);
    bus.Req_Valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_wen", 32'(bus.Mem_W_EN), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (WS + 4) @(negedge clk);
    #1;
    check("midrst_no_resp", 32'(resp_cnt - r0), 32'd0);
    check("midrst_no_write", 32'(wen_cnt - w0), 32'd0);
    check("midrst_idle", 32'(bus.Req_Ready), 32'd1);
    transact(0, 2'b00, 0, 32'h30, 32'h0, d, e);

    r0 = resp_cnt;
    acc = 0;
    last = -1;
    bus.Req_Valid = 1'b1;
    bus.Req_Write = 1'b0;
    bus.Req_Size = 2'b00;
    bus.Req_Addr = 32'h20;
    for (int i = 0; i < 30; i++) begin
      if (bus.Req_Ready) begin
        if (last >= 0)
          check("b2b_gap", 32'(i - last), 32'(WS + 3));
        last = i;
        acc++;
      end
      @(negedge clk);
    end
    bus.Req_Valid = 1'b0;
    repeat (WS + 4) @(negedge clk);
    #1;
    check("b2b_resp_count", 32'(resp_cnt - r0), 32'(acc));
    check("b2b_idle", 32'(bus.Req_Ready), 32'd1);

    for (int i = 0; i < 60; i++) begin
      transact(1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)),
               32'($urandom_range(0, 255)),
               $urandom, d, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator of the multi-cycle MIPS datapath. It accepts one load or store request at a time from the control/datapath side and drives the `RAM` port (`Addr`, `Data`, `W_EN`, `sel`, `Output_Data`) with a configurable number of wait states. It sign- or zero-extends sub-word load data and returns a one-cycle response. It sits between the datapath's MDR/ALUOut registers and `RAM`.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 32: width of the byte address.
- `DATA_WIDTH`, 32: width of the data words.
- `WAIT_STATES`, 1: extra cycles the address is held before a read is sampled or a write strobe fires. Legal range is 0..15.

Ports:
- `CLK`  in  1  clock, rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `Req_Valid`  in  1  request present.
- `Req_Ready`  out  1  unit idle and able to accept a request.
- `Req_Write`  in  1  1 = store, 0 = load.
- `Req_Size`  in  2  00 = word, 01 = halfword, 10 = byte, 11 = treated as word.
- `Req_Unsigned`  in  1  load only: 1 = zero-extend, 0 = sign-extend.
- `Req_Addr`  in  ADDRESS_WIDTH  byte address.
- `Req_WData`  in  DATA_WIDTH  store data, right-justified.
- `Resp_Valid`  out  1  one-cycle completion pulse.
- `Resp_Data`  out  DATA_WIDTH  extended load data; 0 for stores.
- `Resp_Err`  out  1  misaligned access (see Configuration).
- `Mem_Addr`  out  ADDRESS_WIDTH  to `RAM.Addr`.
- `Mem_Data`  out  DATA_WIDTH  to `RAM.Data`.
- `Mem_W_EN`  out  1  to `RAM.W_EN`.
- `Mem_Sel`  out  2  to `RAM.sel`; same encoding as `Req_Size`.
- `Mem_RData`  in  DATA_WIDTH  from `RAM.Output_Data`; combinational read, right-justified.

## Operation
FSM states: IDLE, ACCESS, RESP.

- **IDLE**
  - `Req_Ready`=1.
  - On `Req_Valid`=1 at an edge, capture `Req_*` into internal registers.
  - Go to ACCESS; load the wait counter with `WAIT_STATES`.
- **ACCESS**
  - `Mem_Addr`, `Mem_Sel` and `Mem_Data` are driven from the captured registers and held stable for the whole state.
  - The counter decrements each cycle. The cycle where the counter is 0 is the *last* cycle.
  - Store: `Mem_W_EN`=1 in the last cycle only. `Mem_W_EN` is gated low combinationally whenever `RST`=1.
  - Load: `Mem_RData` is sampled at the end of the last cycle and extended:
    - byte uses bits [7:0];
    - halfword uses bits [15:0];
    - word passes through unchanged;
    - the fill bit is the MSB of the field when `Req_Unsigned`=0, and 0 otherwise.
  - Go to RESP after the last cycle.
- **RESP**
  - `Resp_Valid`=1 for exactly one cycle, with `Resp_Data` and `Resp_Err` valid.
  - Go to IDLE.
  - `Resp_Data` and `Resp_Err` hold their values until the next response.
- `Req_Valid` is ignored outside IDLE. The requester must not assume queuing.
- Outside ACCESS: `Mem_W_EN`=0, and `Mem_Addr`, `Mem_Data`, `Mem_Sel` hold their last values.
- Misalignment is defined as:
  - halfword with `Req_Addr[0]`=1;
  - word with `Req_Addr[1:0]`≠0.

## Timing
- Reset: at the first rising edge with `RST`=1:
  - state goes to IDLE;
  - `Resp_Valid`, `Resp_Err`, `Mem_W_EN` are 0;
  - `Resp_Data`, `Mem_Addr`, `Mem_Data`, `Mem_Sel` are 0.
- While `RST`=1, `Req_Ready`=0.
- Latency, with the request accepted at edge *n*:
  - ACCESS occupies cycles *n*+1 .. *n*+1+`WAIT_STATES`.
  - `Resp_Valid` is high in cycle *n*+2+`WAIT_STATES`.
  - Example: with `WAIT_STATES`=0, the response arrives 2 cycles after acceptance.
- Throughput: one request per `WAIT_STATES`+3 cycles. `Req_Ready` is 1 again in the cycle after RESP.
- Reset mid-operation: any state returns to IDLE.
  - No write occurs in, or after, the cycle in which `RST` is high.
  - The interrupted request produces no response.
- `RST` and `Req_Valid` high together: reset wins and the request is dropped.

## Configuration
Macro: `MEM_ACCESS_MISALIGN_TRAP_EN`.

- Defined:
  - A misaligned request skips ACCESS: no `Mem_W_EN` pulse and no memory read.
  - It goes directly to RESP in cycle *n*+1, with `Resp_Err`=1 and `Resp_Data`=0.
- Undefined:
  - Offending low address bits are forced to 0: bit [0] for halfword, bits [1:0] for word.
  - The access proceeds normally.
  - `Resp_Err` is tied to 0.

## Test plan
- Reset: hold `RST`=1 for 2 cycles with `Req_Valid`=1 → `Req_Ready`=0, `Mem_W_EN`=0, no `Resp_Valid`; after release, `Req_Ready`=1.
- Word store then load, `WAIT_STATES`=1:
  - store 0xDEADBEEF at 0x20 → `Mem_W_EN` high for exactly one cycle, in cycle *n*+2;
  - load from 0x20 → `Resp_Valid` in cycle *n*+3 with `Resp_Data`=0xDEADBEEF.
- Sub-word extension:
  - model returns 0x000000F0 for a byte load at 0x11 → signed gives 0xFFFFFFF0, unsigned gives 0x000000F0;
  - model returns 0x00008001 for a halfword load at 0x12 → signed gives 0xFFFF8001.
- Misaligned word store at 0x22:
  - with the macro: `Resp_Err`=1 in cycle *n*+1, and `Mem_W_EN` never asserted;
  - without the macro: `Mem_Addr`=0x20, `Resp_Err`=0.
- Reset mid-store: assert `RST` in the first ACCESS cycle with `WAIT_STATES`=3 → `Mem_W_EN` stays 0, no response, state is IDLE afterwards.
- Back-to-back: hold `Req_Valid` high continuously with `WAIT_STATES`=0 → requests are accepted every 3 cycles, and exactly one `Resp_Valid` pulse is produced per accepted request.
